// File: rtl/handshake_fifo.sv
// DEPTH-entry show-ahead FIFO between HLS channel endpoints.
// The input side is either pulse-ack (IN_MODE=0) or streaming valid/ready (IN_MODE=1).
module handshake_fifo #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int IN_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             channel_in_data,
    input  logic                         channel_in_en,
    output logic                         channel_in_ack,
    output logic [WIDTH-1:0]             channel_out_data,
    output logic                         channel_out_en,
    input  logic                         channel_out_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && channel_out_rdy;

    generate
        if (IN_MODE == 0) begin : g_pulse_ack
            logic ack_q;

            // ack masks en for one cycle so a held word is not taken twice
            assign push           = channel_in_en && !ack_q && !full;
            assign channel_in_ack = ack_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ack_q <= 1'b0;
                end else begin
                    ack_q <= push;
                end
            end
        end else begin : g_streaming
            // gated by rst so ack drops immediately while reset is held
            assign channel_in_ack = rst && !full;
            assign push           = channel_in_en && channel_in_ack;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop && !full) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push && !empty) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= channel_in_data;
        end
    end

    assign channel_out_data = mem[rd_ptr];
    assign channel_out_en   = !empty;
    assign count            = count_q;

endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo: one pulse-ack and one streaming instance, each tracked by a
// reference model with a data queue, plus table rows and hand sequences for corner cases.
module tb_handshake_fifo;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [31:0] in_data0, in_data1, out_data0, out_data1;
    logic        in_en0, in_en1, ack0, ack1, out_en0, out_en1, rdy0, rdy1;
    logic [2:0]  count0, count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    handshake_fifo #(.WIDTH(32), .DEPTH(4), .IN_MODE(0)) u_fifo0 (
        .clk(clk), .rst(rst0),
        .channel_in_data(in_data0), .channel_in_en(in_en0), .channel_in_ack(ack0),
        .channel_out_data(out_data0), .channel_out_en(out_en0), .channel_out_rdy(rdy0),
        .count(count0)
    );

    handshake_fifo #(.WIDTH(32), .DEPTH(4), .IN_MODE(1)) u_fifo1 (
        .clk(clk), .rst(rst1),
        .channel_in_data(in_data1), .channel_in_en(in_en1), .channel_in_ack(ack1),
        .channel_out_data(out_data1), .channel_out_en(out_en1), .channel_out_rdy(rdy1),
        .count(count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // inputs change 2 time units after the rising edge; checks happen on the falling edge
    task automatic next_drive();
        @(posedge clk);
        #2;
    endtask

    // reference model, pulse-ack instance
    int          m0_count;
    bit          m0_ack;
    logic [31:0] q0[$];
    always @(negedge clk or negedge rst0) begin
        bit p, po;
        if (!rst0) begin
            m0_count = 0; m0_ack = 0; q0.delete();
        end else begin
            check("m0 ack", {31'd0, ack0}, {31'd0, m0_ack});
            check("m0 count", {29'd0, count0}, 32'(m0_count));
            check("m0 out_en", {31'd0, out_en0}, {31'd0, m0_count != 0});
            if (m0_count != 0 && q0.size() > 0) check("m0 data", out_data0, q0[0]);
            p  = in_en0 && !m0_ack && m0_count != 4;
            po = m0_count != 0 && rdy0;
            if (po && q0.size() > 0) void'(q0.pop_front());
            if (p) q0.push_back(in_data0);
            m0_count = m0_count + int'(p) - int'(po);
            m0_ack = p;
        end
    end

    // reference model, streaming instance
    int          m1_count;
    int          pops1 = 0;
    logic [31:0] q1[$];
    always @(negedge clk or negedge rst1) begin
        bit p, po;
        if (!rst1) begin
            m1_count = 0; q1.delete();
        end else begin
            check("m1 ack", {31'd0, ack1}, {31'd0, m1_count != 4});
            check("m1 count", {29'd0, count1}, 32'(m1_count));
            check("m1 out_en", {31'd0, out_en1}, {31'd0, m1_count != 0});
            if (m1_count != 0 && q1.size() > 0) check("m1 data", out_data1, q1[0]);
            p  = in_en1 && m1_count != 4;
            po = m1_count != 0 && rdy1;
            if (po && q1.size() > 0) begin
                void'(q1.pop_front());
                pops1++;
            end
            if (p) q1.push_back(in_data1);
            m1_count = m1_count + int'(p) - int'(po);
        end
    end

    typedef struct {
        logic        en;
        logic [31:0] data;
        logic        rdy;
        logic        exp_ack;
        logic        exp_out_en;
        logic [2:0]  exp_count;
        logic [31:0] exp_data;
    } row_t;

    row_t rows[19];

    initial begin
        int sent, start_pops, guard;

        // fill with held en, drain, then resume (pulse-ack instance)
        rows[0]  = '{1'b1, 32'd123, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
        rows[1]  = '{1'b1, 32'd123, 1'b0, 1'b1, 1'b1, 3'd1, 32'd123};
        rows[2]  = '{1'b1, 32'd123, 1'b0, 1'b0, 1'b1, 3'd1, 32'd123};
        rows[3]  = '{1'b1, 32'd123, 1'b0, 1'b1, 1'b1, 3'd2, 32'd123};
        rows[4]  = '{1'b1, 32'd123, 1'b0, 1'b0, 1'b1, 3'd2, 32'd123};
        rows[5]  = '{1'b1, 32'd123, 1'b0, 1'b1, 1'b1, 3'd3, 32'd123};
        rows[6]  = '{1'b1, 32'd123, 1'b0, 1'b0, 1'b1, 3'd3, 32'd123};
        rows[7]  = '{1'b1, 32'd123, 1'b0, 1'b1, 1'b1, 3'd4, 32'd123};
        rows[8]  = '{1'b1, 32'd123, 1'b0, 1'b0, 1'b1, 3'd4, 32'd123};
        rows[9]  = '{1'b1, 32'd123, 1'b0, 1'b0, 1'b1, 3'd4, 32'd123};
        rows[10] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 3'd4, 32'd123};
        rows[11] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 3'd3, 32'd123};
        rows[12] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 3'd2, 32'd123};
        rows[13] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 3'd1, 32'd123};
        rows[14] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b0, 3'd0, 32'd0};
        rows[15] = '{1'b1, 32'd77,  1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
        rows[16] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 3'd1, 32'd77};
        rows[17] = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 3'd1, 32'd77};
        rows[18] = '{1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 3'd0, 32'd0};

        rst0 = 0; rst1 = 0;
        in_en0 = 0; in_en1 = 0; in_data0 = 0; in_data1 = 0; rdy0 = 0; rdy1 = 0;
        repeat (2) @(negedge clk);
        check("reset ack0", {31'd0, ack0}, 32'd0);
        check("reset ack1", {31'd0, ack1}, 32'd0);
        check("reset out_en0", {31'd0, out_en0}, 32'd0);
        check("reset out_en1", {31'd0, out_en1}, 32'd0);
        check("reset count0", {29'd0, count0}, 32'd0);
        check("reset count1", {29'd0, count1}, 32'd0);
        next_drive();
        rst0 = 1; rst1 = 1;

        for (int i = 0; i < 19; i++) begin
            next_drive();
            in_en0 = rows[i].en; in_data0 = rows[i].data; rdy0 = rows[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d ack", i), {31'd0, ack0}, {31'd0, rows[i].exp_ack});
            check($sformatf("row%0d out_en", i), {31'd0, out_en0}, {31'd0, rows[i].exp_out_en});
            check($sformatf("row%0d count", i), {29'd0, count0}, {29'd0, rows[i].exp_count});
            if (rows[i].exp_out_en)
                check($sformatf("row%0d data", i), out_data0, rows[i].exp_data);
        end

        // streaming: 1..8 back to back with the consumer always ready
        next_drive();
        rdy1 = 1;
        for (int i = 1; i <= 8; i++) begin
            next_drive();
            in_en1 = 1; in_data1 = 32'(i);
            @(negedge clk);
            check("stream ack", {31'd0, ack1}, 32'd1);
            check("stream count<=1", {31'd0, count1 <= 3'd1}, 32'd1);
            if (i > 1) check("stream out", out_data1, 32'(i - 1));
        end
        next_drive();
        in_en1 = 0;
        @(negedge clk);
        check("stream last", out_data1, 32'd8);

        // full stall: four taken, fifth held until one slot frees
        next_drive();
        rdy1 = 0;
        @(negedge clk);
        for (int w = 11; w <= 14; w++) begin
            next_drive();
            in_en1 = 1; in_data1 = 32'(w);
        end
        next_drive();
        in_data1 = 32'd15;
        @(negedge clk);
        check("stall count", {29'd0, count1}, 32'd4);
        check("stall ack", {31'd0, ack1}, 32'd0);
        next_drive();
        rdy1 = 1;
        @(negedge clk);
        check("stall ack with rdy", {31'd0, ack1}, 32'd0);
        check("stall head", out_data1, 32'd11);
        next_drive();
        rdy1 = 0;
        @(negedge clk);
        check("stall freed count", {29'd0, count1}, 32'd3);
        check("stall freed ack", {31'd0, ack1}, 32'd1);
        next_drive();
        in_en1 = 0;
        @(negedge clk);
        check("stall refilled", {29'd0, count1}, 32'd4);
        next_drive();
        rdy1 = 1;
        guard = 0;
        @(negedge clk);
        while (out_en1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("stall drain bound", {31'd0, out_en1}, 32'd0);

        // wrap-around: ten words with the consumer toggling
        start_pops = pops1;
        sent = 0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
            next_drive();
            rdy1 = (c % 2 == 0);
            in_en1 = 1; in_data1 = 32'(101 + sent);
            @(negedge clk);
            if (ack1) sent++;
        end
        next_drive();
        in_en1 = 0; rdy1 = 1;
        guard = 0;
        @(negedge clk);
        while (out_en1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("wrap sent", 32'(sent), 32'd10);
        check("wrap popped", 32'(pops1 - start_pops), 32'd10);

        // async reset with three words buffered
        next_drive();
        rdy1 = 0; in_en1 = 1; in_data1 = 32'd201;
        next_drive();
        in_data1 = 32'd202;
        next_drive();
        in_data1 = 32'd203;
        next_drive();
        in_en1 = 0;
        @(negedge clk);
        check("pre-reset count", {29'd0, count1}, 32'd3);
        #1 rst1 = 0;
        #1;
        check("async count", {29'd0, count1}, 32'd0);
        check("async out_en", {31'd0, out_en1}, 32'd0);
        check("async ack", {31'd0, ack1}, 32'd0);
        next_drive();
        rst1 = 1;
        next_drive();
        in_en1 = 1; in_data1 = 32'd42;
        next_drive();
        in_en1 = 0;
        @(negedge clk);
        check("post-reset out_en", {31'd0, out_en1}, 32'd1);
        check("post-reset first", out_data1, 32'd42);
        check("post-reset count", {29'd0, count1}, 32'd1);
        next_drive();
        rdy1 = 1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/handshake_fifo.md
Name: handshake_fifo

Overview:
- Parametrised successor to the single-word handshake channel block.
- Accepts words on an input channel using a selectable handshake mode and buffers them in a DEPTH-entry FIFO.
- Presents the buffered words on an en/rdy output channel.
- Sits between HLS-generated channel endpoints so that producer and consumer can be decoupled by more than one word.

Parameters:
- WIDTH, 32: data width in bits for both channels.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- IN_MODE, 0: input handshake mode. 0 = pulse-ack (legacy). 1 = streaming valid/ready.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- channel_in_data, input, WIDTH: producer data.
- channel_in_en, input, 1: producer has a word.
- channel_in_ack, output, 1: word accepted. Registered in mode 0, combinational in mode 1.
- channel_out_data, output, WIDTH: FIFO head word.
- channel_out_en, output, 1: head word valid.
- channel_out_rdy, input, 1: consumer takes the head word.
- count, output, clog2(DEPTH+1): current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count go to 0; channel_in_ack=0 and channel_out_en=0 immediately.
  - Storage contents are not reset. channel_out_data is don't-care while channel_out_en=0.
  - Reset mid-transfer discards all buffered words. No ack is issued for a word sampled on the reset edge.
- Derived signals: full = (count==DEPTH), empty = (count==0).
- Input side, IN_MODE=0 (pulse-ack):
  - Push at a rising edge when channel_in_en=1, channel_in_ack=0 and !full. channel_in_data is written at that edge.
  - channel_in_ack goes 1 for exactly one cycle after the push, then returns to 0.
  - While ack=1, en is ignored, so at most one push per 2 cycles.
  - Producer must drop en, or present a new word, after seeing ack.
  - When full, en is held off: no push, no ack. The push happens at the first edge where not full.
- Input side, IN_MODE=1 (streaming):
  - channel_in_ack = !full (combinational).
  - Push at every edge where en && ack. Back-to-back pushes are allowed, one per cycle.
- Output side (both modes):
  - Show-ahead FIFO: channel_out_en = !empty and channel_out_data = word at the read pointer.
  - Pop at an edge where en && rdy.
  - Latency: a word pushed into an empty FIFO at edge N is visible with en=1 in the cycle after edge N. There is no bypass path, so input-to-output latency is 1 cycle.
- Simultaneous events:
  - Push and pop at the same edge: count unchanged, both pointers advance. This is legal when not full.
  - When full, pop only. In mode 1, ack=0 while full even if rdy=1, so no same-cycle push into the slot being freed.
  - When empty, pop is impossible (en=0). A push may occur.
- Pointers: log2(DEPTH) bits wide, wrapping naturally from DEPTH-1 to 0. count uses increment/decrement saturating logic; it must never exceed DEPTH or underflow.
- Ordering: strict FIFO with no reordering, duplication or loss.
- rdy=1 with en=0 has no effect.

Test Plan:
- Reset release, IN_MODE=0, DEPTH=4:
  - Stimulus: producer holds en=1, data=123; consumer rdy=0.
  - Required: one ack pulse per accepted word. count steps 1,2,3,4 at every 2nd cycle. ack stays 0 once count=4 and channel_out_en=1.
- Drain after fill:
  - Stimulus: after the above, raise rdy=1 continuously.
  - Required: out_data=123 on 4 consecutive cycles. count goes 3,2,1,0, then en=0. A new push resumes when not full.
- IN_MODE=1 streaming:
  - Stimulus: push values 1..8 back-to-back with rdy=1.
  - Required: ack=1 every cycle. Output 1..8 in order, each 1 cycle after its push. count stays at most 1.
- IN_MODE=1 full stall:
  - Stimulus: rdy=0 with 5 words offered.
  - Required: 4 accepted, then ack=0. One cycle of rdy=1 pops word 1, and word 5 is accepted at the next edge.
- Wrap-around, DEPTH=4:
  - Stimulus: 10 words with rdy toggling 1,0.
  - Required: all 10 emerge in order and pointers wrap twice without loss.
- Async reset mid-operation:
  - Stimulus: assert rst=0 between edges while count=3.
  - Required: en, ack and count go to 0 immediately, without waiting for a clock edge. After release, the first output is the first new word.
